// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Purpose  : Four-digit seven-segment scan controller (digit select, anodes).
//            Optional per-slot anode blanking: define SEG_SCAN_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
  parameter int DIV   = 100000,
  parameter int GUARD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] digit_en,
  output logic [1:0] S,
  output logic [3:0] an,
  output logic       tick,
  output logic       frame_done
);

  localparam int              c_CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DIV - 1);
  localparam logic [c_CNT_W-1:0] c_GUARD = c_CNT_W'(GUARD);

  logic [c_CNT_W-1:0] r_cnt;
  logic [3:0]         w_onehot;
  logic [3:0]         w_an_next;
  logic               w_term;

  assign w_onehot = 4'b0001 << S;
  assign w_term   = en && (r_cnt == c_LAST);

`ifdef SEG_SCAN_GUARD_EN
  // Blank the start of each slot so the previous digit never ghosts.
  assign w_an_next = (r_cnt < c_GUARD) ? 4'b1111 : ~(w_onehot & digit_en);
`else
  assign w_an_next = ~(w_onehot & digit_en);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      S          <= 2'b00;
      an         <= 4'b1111;
      tick       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      tick       <= 1'b0;
      frame_done <= 1'b0;
      an         <= w_an_next;
      if (w_term) begin
        r_cnt      <= '0;
        S          <= S + 2'd1;
        tick       <= 1'b1;
        frame_done <= (S == 2'd3);
      end else if (en) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Purpose  : Randomized self-checking bench for seg_scan_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

  localparam int DIV   = 4;
  localparam int GUARD = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] digit_en;
  logic [1:0] S;
  logic [3:0] an;
  logic       tick;
  logic       frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  // Reference state: number of enabled cycles since the last reset.
  int m_n      = 0;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIV(DIV), .GUARD(GUARD)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .digit_en   (digit_en),
    .S          (S),
    .an         (an),
    .tick       (tick),
    .frame_done (frame_done)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] de);
    int         s_pre;
    int         c_pre;
    logic [3:0] an_e;
    logic       tk_e;
    logic       fd_e;
    reset    = r;
    en       = e;
    digit_en = de;
    s_pre    = (m_n / DIV) % 4;
    c_pre    = m_n % DIV;
    if (r) begin
      m_n  = 0;
      an_e = 4'hF;
      tk_e = 1'b0;
      fd_e = 1'b0;
    end else begin
      an_e = ~((4'b0001 << s_pre) & de);
`ifdef SEG_SCAN_GUARD_EN
      if (c_pre < GUARD) an_e = 4'hF;
`endif
      tk_e = e && (c_pre == DIV - 1);
      fd_e = tk_e && (s_pre == 3);
      if (e) m_n++;
    end
    @(posedge clk);
    #1;
    check_val("S", 32'(S), 32'((m_n / DIV) % 4));
    check_val("an", 32'(an), 32'(an_e));
    check_val("tick", 32'(tick), 32'(tk_e));
    check_val("frame_done", 32'(frame_done), 32'(fd_e));
    check_val("an_single_low", 32'($countones(~an) <= 1), 32'd1);
  endtask

  initial begin
    logic [3:0] de;
    logic       r;
    logic       e;
    reset    = 1'b1;
    en       = 1'b0;
    digit_en = 4'hF;

    repeat (3) step(1'b1, 1'b1, 4'hF);
    repeat (40) step(1'b0, 1'b1, 4'hF);

    // Freeze exactly in the terminal cycle, then resume.
    for (int i = 0; i < 2 * DIV && (m_n % DIV) != DIV - 1; i++) step(1'b0, 1'b1, 4'hF);
    repeat (10) step(1'b0, 1'b0, 4'hF);
    repeat (4) step(1'b0, 1'b1, 4'hF);

    repeat (32) step(1'b0, 1'b1, 4'b0101);

    // Reset from the middle of digit 2's slot.
    for (int i = 0; i < 8 * DIV && !(((m_n / DIV) % 4) == 2 && (m_n % DIV) == 1); i++)
      step(1'b0, 1'b1, 4'hF);
    step(1'b1, 1'b1, 4'hF);
    repeat (8) step(1'b0, 1'b1, 4'hF);

    de = 4'hF;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 49) == 0);
      e = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 15) == 0) de = 4'($urandom);
      step(r, e, de);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
